// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and constants
package uart_pkg;
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;
   localparam int UART_DEFAULT_BAUD_DIV = 434;
   localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with clear and a one-cycle tick on the last cycle of each bit
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = UART_DEFAULT_BAUD_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);
   localparam int W = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
   logic [W-1:0] cnt;
   assign tick = cnt == W'(BAUD_DIV - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= (clr || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: frames a latched byte as start, 8 data bits LSB-first, optional parity and 1-2 stop bits
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int BAUD_DIV   = UART_DEFAULT_BAUD_DIV,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_tx_start,
   input  logic [7:0] i_tx_data,
   output logic       o_tx_start_clear,
   output logic       o_tx_busy,
   output logic       o_tx_done,
   output logic       o_txd
);
   uart_state_e state_q, state_d;
   logic [7:0] shreg_q, shreg_d, data_q, data_d;
   logic [2:0] idx_q, idx_d;
   logic stop_q, stop_d, txd_d, busy_d, clear_d, done_d, tick, parity;
   // parity comes from the untouched byte copy, not the shifting register
   assign parity = ^data_q ^ (PARITY_ODD != 0);
   uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (state_q == S_IDLE),
      .tick (tick)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= S_IDLE;
      else state_q <= state_d;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         shreg_q          <= '0;
         data_q           <= '0;
         idx_q            <= '0;
         stop_q           <= 1'b0;
         o_txd            <= 1'b1;
         o_tx_busy        <= 1'b0;
         o_tx_start_clear <= 1'b0;
         o_tx_done        <= 1'b0;
      end else begin
         shreg_q          <= shreg_d;
         data_q           <= data_d;
         idx_q            <= idx_d;
         stop_q           <= stop_d;
         o_txd            <= txd_d;
         o_tx_busy        <= busy_d;
         o_tx_start_clear <= clear_d;
         o_tx_done        <= done_d;
      end
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      txd_d   = o_txd;
      busy_d  = o_tx_busy;
      clear_d = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE:
            if (i_tx_start) begin
               state_d = S_START;
               shreg_d = i_tx_data;
               data_d  = i_tx_data;
               txd_d   = 1'b0;
               busy_d  = 1'b1;
               clear_d = 1'b1;
            end
         S_START:
            if (tick) begin
               state_d = S_DATA;
               txd_d   = shreg_q[0];
               shreg_d = shreg_q >> 1;
               idx_d   = '0;
            end
         S_DATA:
            if (tick) begin
               if (idx_q == 3'(UART_DATA_BITS - 1)) begin
                  state_d = PARITY_EN != 0 ? S_PARITY : S_STOP;
                  txd_d   = PARITY_EN != 0 ? parity : 1'b1;
                  stop_d  = 1'b0;
               end else begin
                  txd_d   = shreg_q[0];
                  shreg_d = shreg_q >> 1;
                  idx_d   = idx_q + 3'd1;
               end
            end
         S_PARITY:
            if (tick) begin
               state_d = S_STOP;
               txd_d   = 1'b1;
               stop_d  = 1'b0;
            end
         S_STOP:
            if (tick) begin
               if (stop_q == 1'(STOP_BITS - 1)) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else stop_d = stop_q + 1'b1;
            end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: random frames on four configurations, scoreboarded against a per-cycle line model
module tb_uart_tx_serializer;
   localparam int NC = 4;
   localparam int BD [NC] = '{4, 4, 4, 434};
   localparam int PE [NC] = '{0, 1, 1, 0};
   localparam int PO [NC] = '{0, 0, 1, 0};
   localparam int SB [NC] = '{1, 1, 2, 1};
   localparam int NR [NC] = '{12, 12, 12, 2};

   logic clk = 1'b0;
   int checks = 0, errors = 0, drv_done = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int cfg, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL cfg%0d %s got %0d expected %0d at %0t", cfg, nm, act, exp, $time);
      end
   endtask

   // expected line level at cycle i of a frame, from the frame format alone
   function automatic int lvl(input logic [7:0] d, input int i, input int bd, input int pe, input int po);
      int b;
      b = i / bd;
      if (b == 0) return 0;
      if (b <= 8) return int'(d[b-1]);
      if (pe != 0 && b == 9) return int'((^d) ^ po[0]);
      return 1;
   endfunction

   for (genvar g = 0; g < NC; g++) begin : g_cfg
      localparam int FL = (10 + PE[g] + SB[g] - 1) * BD[g];
      logic rst_n, start, clear, busy, done, txd;
      logic [7:0] data;
      logic [7:0] q[$];

      uart_tx_serializer #(.BAUD_DIV(BD[g]), .PARITY_EN(PE[g]), .PARITY_ODD(PO[g]), .STOP_BITS(SB[g])) dut (
         .clk             (clk),
         .rst_n           (rst_n),
         .i_tx_start      (start),
         .i_tx_data       (data),
         .o_tx_start_clear(clear),
         .o_tx_busy       (busy),
         .o_tx_done       (done),
         .o_txd           (txd)
      );

      initial begin : monitor
         int rem, post_done, exp_start;
         logic [7:0] cur;
         rem = 0; post_done = 0; exp_start = 0; cur = '0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               rem = 0; post_done = 0; exp_start = 0;
               q.delete();
            end else begin
               if (exp_start != 0) begin
                  if (q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL cfg%0d scoreboard_empty got 0 expected 1 entries at %0t", g, $time);
                     cur = '0;
                  end else cur = q.pop_front();
                  rem = FL;
               end
               if (rem > 0) begin
                  chk("txd_frame", g, txd, lvl(cur, FL - rem, BD[g], PE[g], PO[g]));
                  chk("busy_frame", g, busy, 1);
                  chk("clear_frame", g, clear, int'(rem == FL));
                  chk("done_frame", g, done, 0);
                  rem--;
                  post_done = int'(rem == 0);
                  exp_start = 0;
               end else begin
                  chk("txd_idle", g, txd, 1);
                  chk("busy_idle", g, busy, 0);
                  chk("clear_idle", g, clear, 0);
                  chk("done_idle", g, done, post_done);
                  post_done = 0;
                  exp_start = int'(start);
               end
               checks++;
               if (int'(dut.u_baud.cnt) > BD[g] - 1) begin
                  errors++;
                  $display("FAIL cfg%0d baud_cnt got %0d expected <= %0d", g, dut.u_baud.cnt, BD[g] - 1);
               end
            end
         end
      end

      initial begin : driver
         logic [7:0] dq[$];
         int mq[$];
         logic [7:0] d;
         int m, n;
         rst_n = 1'b1; start = 1'b0; data = '0;
         #1 rst_n = 1'b0;
         #1;
         chk("rst_txd", g, txd, 1);
         chk("rst_busy", g, busy, 0);
         chk("rst_clear", g, clear, 0);
         chk("rst_done", g, done, 0);
         repeat (3) @(posedge clk);
         #1 rst_n = 1'b1;
         // modes: 0 idle gap, 1 back-to-back, 2 start pulse in data bit 3, 3 reset in data bit 5
         if (g == 0) begin
            dq = '{8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'h96, 8'h55};
            mq = '{0, 2, 0, 1, 3, 0};
         end else if (g == 3) begin
            dq = '{8'hFF};
            mq = '{0};
         end else begin
            dq = '{8'h07};
            mq = '{0};
         end
         for (int k = 0; k < NR[g]; k++) begin
            dq.push_back(8'($urandom));
            mq.push_back(int'($urandom_range(0, 3)));
         end
         while (dq.size() > 0) begin
            d = dq.pop_front();
            m = mq.pop_front();
            if (m != 1) begin
               n = 0;
               while (busy && n < FL + 20) begin @(posedge clk); #1; n++; end
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            start = 1'b1; data = d;
            q.push_back(d);
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!clear && n < 2 * FL + 20);
            chk("clear_seen", g, clear, 1);
            start = 1'b0; data = '0;
            if (m == 2) begin
               repeat (4 * BD[g]) @(posedge clk);
               #1 start = 1'b1; data = 8'($urandom);
               @(posedge clk);
               #1 start = 1'b0; data = '0;
            end else if (m == 3) begin
               repeat (6 * BD[g] + 1) @(posedge clk);
               #1 rst_n = 1'b0;
               #1;
               chk("async_rst_txd", g, txd, 1);
               chk("async_rst_busy", g, busy, 0);
               chk("async_rst_done", g, done, 0);
               repeat (3) @(posedge clk);
               #1 rst_n = 1'b1;
            end
         end
         n = 0;
         while (busy && n < FL + 20) begin @(posedge clk); #1; n++; end
         repeat (5) @(posedge clk);
         drv_done++;
      end
   end

   initial begin
      int n;
      n = 0;
      while (drv_done < NC && n < 95000) begin @(posedge clk); n++; end
      if (drv_done < NC) begin
         checks++; errors++;
         $display("FAIL timeout drivers_done got %0d expected %0d", drv_done, NC);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
